game_display_scan: RTL and testbench

- Parametrised successor to the game's fixed 8-digit display/LED driver.
- Multiplexes NUM_DIGITS seven-segment digits from a load-strobed frame buffer, so a frame cannot tear mid-scan.
- Adds per-digit blink and score-bar flashing, and generalises the score LED bars.
- Sits between the game FSM/formatter, which produces digit codes, and the board pins AN/DDP/LED.

---
 rtl/game_display_scan.sv | 125 ++++++++++++
 tb/tb_game_display_scan.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_display_scan.sv
// Seven-segment scan driver with a load-strobed frame buffer, per-digit blink
// and flashing thermometer score bars. Everything runs on the single clock.
module game_display_scan #(
    parameter int NUM_DIGITS     = 8,
    parameter int TICK_COUNT     = 100000,
    parameter int BLINK_TICKS    = 250,
    parameter int LED_PER_PLAYER = 8,
    parameter int SCORE_W        = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_DIGITS*6-1:0]     digit_bus,
    input  logic                        load,
    input  logic [NUM_DIGITS-1:0]       blink_mask,
    input  logic                        led_flash,
    input  logic [SCORE_W-1:0]          j1_points,
    input  logic [SCORE_W-1:0]          j2_points,
    output logic [NUM_DIGITS-1:0]       AN,
    output logic [7:0]                  DDP,
    output logic [2*LED_PER_PLAYER-1:0] LED
);

    localparam int TW = $clog2(TICK_COUNT);
    localparam int SW = $clog2(NUM_DIGITS);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_COUNT - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    logic [TW-1:0]              tick_cnt;
    logic [SW-1:0]              scan_idx;
    logic [BW-1:0]              blink_cnt;
    logic                       blink_phase;
    logic [NUM_DIGITS*6-1:0]    frame;
    logic                       tick;
    logic [5:0]                 cur_digit;
    logic                       blank;
    logic [NUM_DIGITS-1:0]      an_next;
    logic [7:0]                 ddp_next;
    logic [LED_PER_PLAYER-1:0]  j1_bar;
    logic [LED_PER_PLAYER-1:0]  j2_bar;

    // Segment patterns {a,b,c,d,e,f,g}, active low.
    function automatic logic [6:0] decode(input logic [3:0] c);
        case (c)
            4'h0:    decode = 7'b0000001;
            4'h1:    decode = 7'b1001111;
            4'h2:    decode = 7'b0010010;
            4'h3:    decode = 7'b0000110;
            4'h4:    decode = 7'b1001100;
            4'h5:    decode = 7'b0100001;
            4'h6:    decode = 7'b1001110;
            4'h7:    decode = 7'b1110001;
            4'h8:    decode = 7'b1000100;
            4'h9:    decode = 7'b0011000;
            4'hA:    decode = 7'b0001000;
            4'hB:    decode = 7'b1100000;
            4'hC:    decode = 7'b0100100;
            4'hD:    decode = 7'b1110000;
            4'hE:    decode = 7'b0110000;
            default: decode = 7'b1000001;
        endcase
    endfunction

    assign tick = (tick_cnt == TICK_LAST);

    always_comb begin
        cur_digit = frame[6*int'(scan_idx) +: 6];
        blank     = !cur_digit[5] || (blink_mask[scan_idx] && blink_phase);
        an_next   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_next[i] = (int'(scan_idx) != i);
        end
        ddp_next = {decode(cur_digit[4:1]), ~cur_digit[0]};
        if (blank) begin
            an_next  = '1;
            ddp_next = 8'hFF;
        end
        j1_bar = '0;
        j2_bar = '0;
        for (int i = 0; i < LED_PER_PLAYER; i++) begin
            j1_bar[i] = (j1_points > SCORE_W'(i));
            j2_bar[i] = (j2_points > SCORE_W'(i));
        end
        // Flashing bars go dark together during the blank half of the blink.
        if (led_flash && blink_phase) begin
            j1_bar = '0;
            j2_bar = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt    <= '0;
            scan_idx    <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            frame       <= '0;
            AN          <= '1;
            DDP         <= 8'hFF;
            LED         <= '0;
        end else begin
            LED <= {j2_bar, j1_bar};
            // A load coinciding with a tick is seen from the following tick.
            if (load) begin
                frame <= digit_bus;
            end
            if (tick) begin
                tick_cnt <= '0;
                AN       <= an_next;
                DDP      <= ddp_next;
                scan_idx <= (scan_idx == SCAN_LAST) ? '0 : scan_idx + 1'b1;
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_game_display_scan.sv
// Directed bench for game_display_scan with NUM_DIGITS=4, TICK_COUNT=4,
// BLINK_TICKS=2, LED_PER_PLAYER=8; expected values are hand-decoded.
module tb_game_display_scan;

    logic        clock;
    logic        reset;
    logic [23:0] digit_bus;
    logic        load;
    logic [3:0]  blink_mask;
    logic        led_flash;
    logic [7:0]  j1_points;
    logic [7:0]  j2_points;
    logic [3:0]  AN;
    logic [7:0]  DDP;
    logic [15:0] LED;

    int n_cmp;
    int n_bad;

    // Frames as {d3,d2,d1,d0}, each digit {en, char[3:0], dp}.
    localparam logic [23:0] FRAME_SCAN  = {6'h3C, 6'h00, 6'h25, 6'h22};
    localparam logic [23:0] FRAME_NEW1  = {6'h3C, 6'h00, 6'h34, 6'h22};
    localparam logic [23:0] FRAME_BLINK = {6'h38, 6'h32, 6'h2A, 6'h20};

    game_display_scan #(
        .NUM_DIGITS(4), .TICK_COUNT(4), .BLINK_TICKS(2),
        .LED_PER_PLAYER(8), .SCORE_W(8)
    ) dut (
        .clock(clock), .reset(reset), .digit_bus(digit_bus), .load(load),
        .blink_mask(blink_mask), .led_flash(led_flash),
        .j1_points(j1_points), .j2_points(j2_points),
        .AN(AN), .DDP(DDP), .LED(LED)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Leaves the bench 1 ns after the last reset edge: tick counter at 0.
    task automatic do_reset();
        reset = 1'b1;
        load  = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        load      = 1'b1;
        digit_bus = FRAME_SCAN;
        j1_points = 8'd8;
        step(2);
        n_cmp++;
        if (AN !== 4'hF) begin
            n_bad++; $display("FAIL reset_an got=%b exp=1111", AN);
        end
        n_cmp++;
        if (DDP !== 8'hFF) begin
            n_bad++; $display("FAIL reset_ddp got=%h exp=ff", DDP);
        end
        n_cmp++;
        if (LED !== 16'h0000) begin
            n_bad++; $display("FAIL reset_led got=%h exp=0000", LED);
        end
        load      = 1'b0;
        reset     = 1'b0;
        j1_points = 8'd0;
        step(4);
        n_cmp++;
        if ({AN, DDP} !== 12'hFFF) begin
            n_bad++; $display("FAIL reset_load_ignored got=%h exp=fff", {AN, DDP});
        end
    endtask

    task automatic test_scan();
        logic [11:0] exp_seq [5];
        exp_seq = '{12'hE9F, 12'hD24, 12'hFFF, 12'h761, 12'hE9F};
        do_reset();
        digit_bus = FRAME_SCAN;
        load      = 1'b1;
        step(1);
        load = 1'b0;
        step(3);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({AN, DDP} !== exp_seq[i]) begin
                n_bad++; $display("FAIL scan_slot%0d got=%h exp=%h", i, {AN, DDP}, exp_seq[i]);
            end
            if (i == 0) begin
                step(1);
                n_cmp++;
                if ({AN, DDP} !== 12'hE9F) begin
                    n_bad++; $display("FAIL scan_hold got=%h exp=e9f", {AN, DDP});
                end
                step(3);
            end else if (i < 4) begin
                step(4);
            end
        end
    endtask

    // Continues from test_scan: bench sits just after the digit-0 tick.
    task automatic test_load_on_tick();
        step(3);
        digit_bus = FRAME_NEW1;
        load      = 1'b1;
        step(1);
        load = 1'b0;
        n_cmp++;
        if ({AN, DDP} !== 12'hD24) begin
            n_bad++; $display("FAIL load_tick_old got=%h exp=d24", {AN, DDP});
        end
        step(4);
        n_cmp++;
        if ({AN, DDP} !== 12'hFFF) begin
            n_bad++; $display("FAIL load_tick_d2 got=%h exp=fff", {AN, DDP});
        end
        step(12);
        n_cmp++;
        if ({AN, DDP} !== 12'hD11) begin
            n_bad++; $display("FAIL load_tick_new got=%h exp=d11", {AN, DDP});
        end
    endtask

    task automatic test_blink();
        logic [11:0] exp_seq [8];
        exp_seq = '{12'hE03, 12'hD43, 12'hFFF, 12'h749,
                    12'hE03, 12'hD43, 12'hFFF, 12'h749};
        do_reset();
        blink_mask = 4'b0101;
        digit_bus  = FRAME_BLINK;
        load       = 1'b1;
        step(1);
        load = 1'b0;
        step(3);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if ({AN, DDP} !== exp_seq[i]) begin
                n_bad++; $display("FAIL blink_slot%0d got=%h exp=%h", i, {AN, DDP}, exp_seq[i]);
            end
            if (i < 7) step(4);
        end
        blink_mask = 4'b0000;
        step(12);
        n_cmp++;
        if ({AN, DDP} !== 12'hB31) begin
            n_bad++; $display("FAIL blink_unmasked got=%h exp=b31", {AN, DDP});
        end
    endtask

    task automatic test_led();
        logic [7:0]  pts [4];
        logic [15:0] exp_led [4];
        pts     = '{8'd0, 8'd3, 8'd8, 8'd200};
        exp_led = '{16'h1F00, 16'h1F07, 16'h1FFF, 16'h1FFF};
        do_reset();
        led_flash = 1'b0;
        j2_points = 8'd5;
        for (int i = 0; i < 4; i++) begin
            j1_points = pts[i];
            if (i > 0) begin
                n_cmp++;
                if (LED !== exp_led[i-1]) begin
                    n_bad++; $display("FAIL led_latency%0d got=%h exp=%h", i, LED, exp_led[i-1]);
                end
            end
            step(1);
            n_cmp++;
            if (LED !== exp_led[i]) begin
                n_bad++; $display("FAIL led_bar_j1_%0d got=%h exp=%h", pts[i], LED, exp_led[i]);
            end
        end
    endtask

    task automatic test_led_flash();
        int          gap [5];
        logic [15:0] exp_led [5];
        gap     = '{8, 1, 7, 1, 8};
        exp_led = '{16'h1F07, 16'h0000, 16'h0000, 16'h1F07, 16'h0000};
        do_reset();
        j1_points = 8'd3;
        j2_points = 8'd5;
        led_flash = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(gap[i]);
            n_cmp++;
            if (LED !== exp_led[i]) begin
                n_bad++; $display("FAIL led_flash%0d got=%h exp=%h", i, LED, exp_led[i]);
            end
        end
        led_flash = 1'b0;
        step(1);
        n_cmp++;
        if (LED !== 16'h1F07) begin
            n_bad++; $display("FAIL led_flash_off got=%h exp=1f07", LED);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        blink_mask = 4'b0000;
        j1_points  = 8'd3;
        j2_points  = 8'd5;
        digit_bus  = FRAME_BLINK;
        load       = 1'b1;
        step(1);
        load = 1'b0;
        step(8);
        n_cmp++;
        if ({AN, DDP, LED} !== {12'hD43, 16'h1F07}) begin
            n_bad++; $display("FAIL mid_before got=%h exp=d431f07", {AN, DDP, LED});
        end
        reset = 1'b1;
        step(1);
        n_cmp++;
        if ({AN, DDP, LED} !== {12'hFFF, 16'h0000}) begin
            n_bad++; $display("FAIL mid_reset got=%h exp=fff0000", {AN, DDP, LED});
        end
        reset = 1'b0;
        step(3);
        n_cmp++;
        if ({AN, DDP} !== 12'hFFF) begin
            n_bad++; $display("FAIL mid_no_early_tick got=%h exp=fff", {AN, DDP});
        end
        step(1);
        n_cmp++;
        if ({AN, DDP} !== 12'hFFF) begin
            n_bad++; $display("FAIL mid_frame_cleared got=%h exp=fff", {AN, DDP});
        end
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(3);
        n_cmp++;
        if ({AN, DDP} !== 12'hD43) begin
            n_bad++; $display("FAIL mid_restart_d1 got=%h exp=d43", {AN, DDP});
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        reset      = 1'b1;
        load       = 1'b0;
        digit_bus  = '0;
        blink_mask = '0;
        led_flash  = 1'b0;
        j1_points  = '0;
        j2_points  = '0;
        test_reset();
        test_scan();
        test_load_on_tick();
        test_blink();
        test_led();
        test_led_flash();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
